// File: rtl/decoder38_pkg.sv
// rtl/decoder38_pkg.sv - shared types, widths and decode helper for decoder38_hold
//
// Purpose : code/one-hot widths, FSM state type and the code-to-one-hot
//           function shared by the decoder top and its combinational front end.
// Contents: IN_W, OUT_W, state_t {ST_IDLE, ST_HOLD}, onehot().
package decoder38_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;

  // The literals carry an ST_ prefix because the top has a parameter named HOLD.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - combinational 3:8 one-hot decoder
//
// Purpose: pure combinational decode placed in front of the out register.
// Ports  : code       [IN_W-1:0]  input  encoded index
//          onehot_out [OUT_W-1:0] output exactly one bit set at position code
module dec_onehot
  import decoder38_pkg::*;
(
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] onehot_out
);

  assign onehot_out = onehot(code);

endmodule

// File: rtl/decoder38_hold.sv
// rtl/decoder38_hold.sv - sequential 3:8 decoder holding each one-hot for HOLD cycles
//
// Purpose: accepts a code over valid/ready and drives the matching one-hot
//          line for HOLD cycles, then releases it. Back-to-back accepts on
//          the last hold cycle switch directly to the next one-hot.
// Macro  : DEC38_BREAK_BEFORE_MAKE_EN - when defined, codes are accepted only
//          in idle, forcing at least one all-zero cycle between pulses.
// Ports  : clk      input               rising-edge clock
//          rst_n    input               asynchronous active-low reset
//          en       input               block enable; low aborts and idles
//          in_valid input               in_code valid this cycle
//          in_ready output              block can accept a code this cycle
//          in_code  input  [IN_W-1:0]   code to decode
//          out      output [OUT_W-1:0]  registered one-hot (or zero)
//          busy     output              registered, equals |out
module decoder38_hold
  import decoder38_pkg::*;
#(
  parameter int IN_W  = decoder38_pkg::IN_W,
  parameter int OUT_W = decoder38_pkg::OUT_W,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic [OUT_W-1:0] out,
  output logic             busy
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [OUT_W-1:0]   out_nx;
  logic               busy_nx;
  logic [OUT_W-1:0]   code_oh;
  logic               accept;

  dec_onehot u_dec (
    .code       (in_code),
    .onehot_out (code_oh)
  );

`ifdef DEC38_BREAK_BEFORE_MAKE_EN
  assign in_ready = en & (state == ST_IDLE);
`else
  // Accepting on the last hold cycle lets pulses abut with no zero gap.
  assign in_ready = en & ((state == ST_IDLE) |
                          ((state == ST_HOLD) & (cnt == '0)));
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = out;
    busy_nx  = busy;
    if (!en) begin
      // Disable aborts any pulse; nothing is remembered for later.
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      out_nx   = '0;
      busy_nx  = 1'b0;
    end else if (accept) begin
      state_nx = ST_HOLD;
      cnt_nx   = CNT_W'(HOLD - 1);
      out_nx   = code_oh;
      busy_nx  = 1'b1;
    end else if (state == ST_HOLD) begin
      if (cnt != '0) begin
        cnt_nx = cnt - 1'b1;
      end else begin
        state_nx = ST_IDLE;
        out_nx   = '0;
        busy_nx  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      out   <= out_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: doc/decoder38_hold.md
Name: decoder38_hold

Overview:
- Sequential 3-to-8 decoder; the reverse direction of the 8:3 priority encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles, then releases it.
- Sits downstream of the priority encoder to regenerate per-channel strobes, such as grant or select pulses, from an encoded index.

Parameters:
- IN_W, 3, code width; fixed at 3 for this block.
- OUT_W, 8, one-hot width; must equal 2**IN_W.
- HOLD, 4, cycles each one-hot output stays asserted; legal range 1..255.
- CNT_W, 8, hold-counter width; must satisfy HOLD <= 2**CNT_W - 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces outputs idle
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- in_code  input  IN_W  code to decode
- out  output  OUT_W  registered one-hot output
- busy  output  1  registered; high while out is non-zero

Behaviour:
- Reset (rst_n low, async assert): out=0, busy=0, state=IDLE, cnt=0. Release is synchronous to clk.
- States: IDLE, HOLD. Both the state typedef and the encoding come from the package.
- in_ready is combinational:
  - en & (state==IDLE), or
  - en & (state==HOLD) & (cnt==0).
- Accept = in_valid & in_ready, sampled at the rising edge.
- On accept: next cycle out = 1<<in_code, busy=1, state=HOLD, cnt=HOLD-1. Latency from accept edge to out is 1 cycle.
- HOLD with cnt>0: cnt decrements; out is held.
- HOLD with cnt==0 and no accept: out=0, busy=0, state=IDLE next cycle. out is therefore high exactly HOLD cycles.
- HOLD with cnt==0 and accept (back-to-back): out switches directly to the new one-hot, with no zero cycle between pulses. A code equal to the previous one extends the pulse seamlessly.
- HOLD=1: every pulse is one cycle wide; sustained in_valid gives a new one-hot every cycle.
- en low:
  - in_ready=0.
  - Any active pulse aborts: next edge out=0, busy=0, state=IDLE, cnt=0.
  - in_valid is ignored; no code is stored for later.
- en reasserted: the block starts from IDLE; no pulse is replayed.
- in_valid without in_ready: no state change. The source must hold in_code stable until accept.
- Invariants: out is always zero or exactly one-hot; busy == |out.
- Reset asserted mid-pulse: out clears immediately (async), independent of clk.

Optional Feature:
- Macro: DEC38_BREAK_BEFORE_MAKE_EN.
- Defined:
  - in_ready = en & (state==IDLE) only.
  - At least one all-zero out cycle separates consecutive pulses. The minimum pulse period becomes HOLD+1 cycles.
- Undefined: back-to-back behaviour as described above (pulse period HOLD).

Decomposition:
- Package decoder38_pkg holds:
  - localparams IN_W=3, OUT_W=8;
  - typedef enum state_t {IDLE, HOLD};
  - function onehot(code) returning OUT_W bits.
- One natural sub-module, dec_onehot: a purely combinational 3:8 decoder instantiated in front of the out register. The FSM, counter and handshake stay in decoder38_hold.

Test Plan:
- Reset release, en=1, in_code=5 valid one cycle -> in_ready=1 at accept; out=8'b0010_0000 for exactly 4 cycles starting 1 cycle later; busy tracks it; then out=0.
- in_valid held high, codes 0,1,2,...,7 presented and advanced only on accept (no macro) -> out 8'h01,8'h02,...,8'h80, each exactly 4 cycles, no zero gaps; in_ready high only in IDLE and on the last HOLD cycle.
- Same stimulus with DEC38_BREAK_BEFORE_MAKE_EN -> each one-hot held 4 cycles followed by exactly 1 cycle out=0; pulse period 5.
- Pulse for code 3 active, en dropped on 2nd HOLD cycle -> out=0 and busy=0 at the next edge; in_ready=0 while en=0; in_valid with code 6 during en=0 produces nothing after en returns.
- rst_n asserted asynchronously mid-pulse (code 7) -> out=0 before the next clk edge; after release, with no in_valid, out stays 0.
- HOLD=1 build, in_valid continuous with codes 7,0,7 -> out 8'h80, 8'h01, 8'h80 on consecutive cycles; every observed out value is zero or one-hot.
